game_controller: RTL and testbench
==================================

Name: game_controller

Overview:
Moore FSM that sequences the 5-bit game countdown counter for a reaction game. Shared with the counter on the 4 Hz game clock, it holds the counter at reload (31) between rounds. After a fixed arming delay it enables the countdown and judges the player's hit against a target value. It reports win, lose or timeout and keeps a saturating win-streak score.

Parameters:
ARM_CYCLES, 8, clock cycles spent in ARM before the countdown starts (>=1)
RESULT_HOLD, 12, cycles WIN/LOSE is displayed before returning to IDLE (>=1)
SCORE_W, 4, width of streak score

Ports:
clk_4_i  input  1  game clock; all state changes on its rising edge
rst_ni  input  1  asynchronous, active-low reset
start_i  input  1  single-cycle start pulse (already debounced)
hit_i  input  1  single-cycle player-hit pulse (already debounced)
target_i  input  5  target count; sampled only on IDLE->ARM
count_i  input  5  current value of the countdown counter
counter_en_o  output  1  decrement enable to the counter
counter_rst_no  output  1  synchronous active-low reload to the counter (reloads to 31)
playing_o  output  1  high in PLAY
win_o  output  1  high in WIN
lose_o  output  1  high in LOSE
score_o  output  SCORE_W  current win streak
state_o  output  3  IDLE=0, ARM=1, PLAY=2, WIN=3, LOSE=4

Behaviour:
- Clock is one clock, clk_4_i. Reset is asynchronous and active-low on rst_ni.
- Reset takes effect immediately, including mid-round:
  - state=IDLE; score=0; target_q=0; arm/hold timers=0.
  - Outputs: counter_en_o=0, counter_rst_no=0, playing/win/lose=0, state_o=0.
- All outputs decode from registered state only (Moore). score_o is a register.
- counter_rst_no=0 in every state except PLAY. counter_en_o=1 only in PLAY. Result: count_i=31 on the first PLAY cycle.
- IDLE:
  - start_i -> ARM next cycle; target_q<=target_i; arm timer<=ARM_CYCLES-1.
  - hit_i alone is ignored. start_i and hit_i together: start wins and the hit is ignored.
- ARM:
  - Timer decrements each cycle.
  - hit_i in ARM is a false start -> LOSE; this has priority over the timer expiring.
  - Timer==0 with no hit -> PLAY. ARM therefore lasts exactly ARM_CYCLES cycles.
- PLAY (evaluated each cycle on the sampled count_i):
  - hit_i and count_i==target_q -> WIN.
  - hit_i and count_i!=target_q -> LOSE.
  - No hit and count_i==0 -> LOSE (timeout).
  - A hit has priority over timeout, so hit at count 0 with target_q=0 -> WIN.
  - Counter may wrap to 31 on the exit edge; harmless, since it is held at reload from the next cycle.
- Maximum PLAY length is 32 cycles (counts 31..0).
- WIN / LOSE:
  - Hold timer loaded with RESULT_HOLD-1 on entry.
  - Stay RESULT_HOLD cycles, then go to IDLE.
  - start_i and hit_i are ignored.
- start_i in ARM/PLAY/WIN/LOSE is ignored. No restart mid-round.
- Score:
  - On the transition into WIN, score increments, saturating at 2^SCORE_W-1.
  - On the transition into LOSE, score clears to 0.
  - Otherwise unchanged.
- target_i changes after IDLE->ARM have no effect until the next start.
- Unused state encodings (5-7) -> IDLE next cycle, score unchanged.
- Timers are sized to clog2(max(ARM_CYCLES,RESULT_HOLD)); no wrap-around possible.

Test Plan:
(Bench instantiates game_controller plus the real game counter, with default parameters.)
- Win round: target_i=20, pulse start_i. Expect 8 ARM cycles, then PLAY with count_i=31. Hit when count_i==20 -> next cycle win_o=1, score_o 0->1, counter_en_o=0, counter_rst_no=0. 12 cycles later state_o=0.
- False start: start_i, then hit_i on the 3rd ARM cycle -> next cycle lose_o=1 and score_o=0. counter_en_o never asserted and count_i stays 31.
- Timeout/wrong hit: no hit -> count_i reaches 0 after 31 PLAY cycles, next cycle lose_o=1. Separate round: hit at count_i=19 with target 20 -> LOSE.
- Boundary target: target_i=0 with hit exactly at count_i==0 -> WIN, not timeout. target_i=31 with hit on the first PLAY cycle -> WIN.
- Saturation and target latch: 16 consecutive wins -> score_o=15 held. A round with target_i changed 20->5 mid-PLAY still wins on a hit at 20.
- Async reset: assert rst_ni low between clock edges mid-PLAY (count_i=12, score=3). Outputs go to reset values immediately without a clock edge; state_o=0, score_o=0. Release, then start_i begins a clean round.

Source files
------------

// File: rtl/game_controller.sv
// -----------------------------------------------------------------------------
// game_controller
// Moore FSM sequencing the 5-bit countdown counter of a reaction game on the
// 4 Hz game clock. Holds the counter at reload outside PLAY, arms for a fixed
// delay, judges the player's hit against a latched target and keeps a
// saturating win-streak score.
//
// Ports:
//   clk_4_i        game clock, all state changes on rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        single-cycle start pulse
//   hit_i          single-cycle player-hit pulse
//   target_i       target count, latched on IDLE->ARM
//   count_i        current countdown counter value
//   counter_en_o   decrement enable to the counter (PLAY only)
//   counter_rst_no synchronous active-low reload to the counter (low outside PLAY)
//   playing_o      high in PLAY
//   win_o          high in WIN
//   lose_o         high in LOSE
//   score_o        current win streak (saturating)
//   state_o        IDLE=0, ARM=1, PLAY=2, WIN=3, LOSE=4
// -----------------------------------------------------------------------------
module game_controller #(
   parameter int unsigned ARM_CYCLES  = 8,
   parameter int unsigned RESULT_HOLD = 12,
   parameter int unsigned SCORE_W     = 4
) (
   input  logic               clk_4_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic               hit_i,
   input  logic [4:0]         target_i,
   input  logic [4:0]         count_i,
   output logic               counter_en_o,
   output logic               counter_rst_no,
   output logic               playing_o,
   output logic               win_o,
   output logic               lose_o,
   output logic [SCORE_W-1:0] score_o,
   output logic [2:0]         state_o
);

   localparam int unsigned MAX_C = (ARM_CYCLES > RESULT_HOLD) ? ARM_CYCLES : RESULT_HOLD;
   localparam int unsigned TMR_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_PLAY = 3'd2,
      S_WIN  = 3'd3,
      S_LOSE = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [4:0]         target_q, target_d;
   logic [SCORE_W-1:0] score_q, score_d;

   always_ff @(posedge clk_4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         target_q <= '0;
         score_q  <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         target_q <= target_d;
         score_q  <= score_d;
      end
   end

   // One timer serves both ARM and the WIN/LOSE hold; they never overlap.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      target_d = target_q;
      score_d  = score_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_ARM;
               target_d = target_i;
               timer_d  = TMR_W'(ARM_CYCLES - 1);
            end
         end
         S_ARM: begin
            if (hit_i) begin
               state_d = S_LOSE;
               timer_d = TMR_W'(RESULT_HOLD - 1);
               score_d = '0;
            end else if (timer_q == '0) begin
               state_d = S_PLAY;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_PLAY: begin
            // A hit is judged before the timeout so hit-at-zero on target 0 wins.
            if (hit_i && (count_i == target_q)) begin
               state_d = S_WIN;
               timer_d = TMR_W'(RESULT_HOLD - 1);
               if (score_q != '1) score_d = score_q + 1'b1;
            end else if (hit_i || (count_i == 5'd0)) begin
               state_d = S_LOSE;
               timer_d = TMR_W'(RESULT_HOLD - 1);
               score_d = '0;
            end
         end
         S_WIN, S_LOSE: begin
            if (timer_q == '0) state_d = S_IDLE;
            else               timer_d = timer_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign counter_en_o   = (state_q == S_PLAY);
   assign counter_rst_no = (state_q == S_PLAY);
   assign playing_o      = (state_q == S_PLAY);
   assign win_o          = (state_q == S_WIN);
   assign lose_o         = (state_q == S_LOSE);
   assign score_o        = score_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_game_controller.sv
// -----------------------------------------------------------------------------
// tb_game_controller
// Directed bench for game_controller with a behavioural 5-bit countdown counter
// (reload to 31 on counter_rst_no low, decrement on counter_en_o).
// -----------------------------------------------------------------------------
module tb_game_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       hit = 1'b0;
   logic [4:0] target = 5'd0;
   logic [4:0] count_q;
   logic       counter_en;
   logic       counter_rst_n;
   logic       playing, win, lose;
   logic [3:0] score;
   logic [2:0] state;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned exp_score = 0;

   always #5 clk = ~clk;

   game_controller #(
      .ARM_CYCLES (8),
      .RESULT_HOLD(12),
      .SCORE_W    (4)
   ) dut (
      .clk_4_i       (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .hit_i         (hit),
      .target_i      (target),
      .count_i       (count_q),
      .counter_en_o  (counter_en),
      .counter_rst_no(counter_rst_n),
      .playing_o     (playing),
      .win_o         (win),
      .lose_o        (lose),
      .score_o       (score),
      .state_o       (state)
   );

   // Countdown counter the controller drives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              count_q <= 5'd31;
      else if (!counter_rst_n) count_q <= 5'd31;
      else if (counter_en)     count_q <= count_q - 5'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses start, walks through ARM and lands on the first PLAY cycle.
   task automatic start_round(input logic [4:0] tgt);
      logic en_any;
      en_any = 1'b0;
      target = tgt;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("arm_entry_state", state, 1);
      for (int i = 0; i < 7; i++) begin
         step();
         en_any |= counter_en;
      end
      check("arm_len_state", state, 1);
      check("arm_no_enable", en_any, 0);
      step();
      check("play_state", state, 2);
      check("play_playing", playing, 1);
      check("play_first_count", count_q, 31);
   endtask

   task automatic run_to_count(input int c);
      for (int i = 0; i < 31 - c; i++) step();
      check("play_count", count_q, c);
      check("still_playing", playing, 1);
   endtask

   task automatic hit_now();
      hit = 1'b1;
      step();
      hit = 1'b0;
   endtask

   task automatic expect_win(input string tag);
      exp_score = (exp_score < 15) ? exp_score + 1 : 15;
      check({tag, "_win"}, win, 1);
      check({tag, "_state"}, state, 3);
      check({tag, "_score"}, score, exp_score);
   endtask

   task automatic expect_lose(input string tag);
      exp_score = 0;
      check({tag, "_lose"}, lose, 1);
      check({tag, "_state"}, state, 4);
      check({tag, "_score"}, score, 0);
   endtask

   // Result display lasts 12 cycles counting the entry cycle.
   task automatic hold_to_idle();
      for (int i = 0; i < 11; i++) step();
      check("hold_last_cycle", (win | lose), 1);
      step();
      check("back_idle", state, 0);
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_state", state, 0);
      check("rst_score", score, 0);
      check("rst_en", counter_en, 0);
      check("rst_crst", counter_rst_n, 0);
      check("rst_flags", {playing, win, lose}, 0);
      step();
      rst_n = 1'b1;
      step();
      check("idle_state", state, 0);

      // hit alone in IDLE is ignored
      hit_now();
      check("idle_hit_ignored", state, 0);

      // Win round
      start_round(5'd20);
      run_to_count(20);
      hit_now();
      expect_win("win1");
      check("win1_en", counter_en, 0);
      check("win1_crst", counter_rst_n, 0);
      hold_to_idle();

      // False start on 3rd ARM cycle
      target = 5'd20;
      start  = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("fs_arm3", state, 1);
      hit_now();
      expect_lose("fs");
      check("fs_count", count_q, 31);
      check("fs_en", counter_en, 0);
      hold_to_idle();

      // Timeout
      start_round(5'd10);
      run_to_count(0);
      step();
      expect_lose("timeout");
      hold_to_idle();

      // Wrong hit
      start_round(5'd20);
      run_to_count(19);
      hit_now();
      expect_lose("wrong");
      hold_to_idle();

      // Target 0 hit at count 0 wins
      start_round(5'd0);
      run_to_count(0);
      hit_now();
      expect_win("t0");
      hold_to_idle();

      // Target 31 hit on first PLAY cycle, start+hit together in IDLE
      target = 5'd31;
      start = 1'b1;
      hit   = 1'b1;
      step();
      start = 1'b0;
      hit   = 1'b0;
      check("start_beats_hit", state, 1);
      for (int i = 0; i < 8; i++) step();
      check("t31_play", state, 2);
      hit_now();
      expect_win("t31");
      hold_to_idle();

      // Saturation: 14 more wins takes the streak to 16
      for (int r = 0; r < 14; r++) begin
         start_round(5'd31);
         hit_now();
         expect_win("sat");
         hold_to_idle();
      end
      check("sat_score", score, 15);

      // Target latched at start: change mid-PLAY has no effect
      start_round(5'd20);
      target = 5'd5;
      run_to_count(20);
      hit_now();
      expect_win("latch");
      check("latch_held15", score, 15);
      // start during result display is ignored
      start = 1'b1;
      step();
      start = 1'b0;
      check("win_start_ignored", state, 3);
      for (int i = 0; i < 10; i++) step();
      step();
      check("latch_idle", state, 0);

      // Build score 3, then async reset mid-PLAY at count 12
      start_round(5'd20);
      run_to_count(19);
      hit_now();
      expect_lose("pre_rst");
      hold_to_idle();
      for (int r = 0; r < 3; r++) begin
         start_round(5'd31);
         hit_now();
         expect_win("pre_rst_w");
         hold_to_idle();
      end
      start_round(5'd20);
      run_to_count(12);
      check("pre_rst_score", score, 3);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_state", state, 0);
      check("arst_score", score, 0);
      check("arst_en", counter_en, 0);
      check("arst_crst", counter_rst_n, 0);
      check("arst_flags", {playing, win, lose}, 0);
      exp_score = 0;
      rst_n = 1'b1;
      step();
      check("post_rst_idle", state, 0);
      start_round(5'd31);
      hit_now();
      expect_win("post_rst");
      hold_to_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
